// File: rtl/zmod_sample_conditioner.sv
// ============================================================================
// Module   : zmod_sample_conditioner
// Brief    : Per-channel ZMOD raw-sample format conversion with 2^k block
//            averaging and a single-cycle output strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module zmod_sample_conditioner #(
    parameter int N_CHANNELS        = 2,
    parameter int ZMOD_DATA_SIZE    = 14,
    parameter int SAMPLER_DATA_SIZE = 16,
    parameter int MAX_AVG_LOG2      = 4
) (
    input  logic                                    i_clock,
    input  logic                                    i_reset,
    input  logic                                    i_valid,
    input  logic [N_CHANNELS*ZMOD_DATA_SIZE-1:0]    i_raw_data,
    input  logic [1:0]                              i_mode,
    input  logic [2:0]                              i_avg_log2,
    input  logic                                    i_clear,
    output logic                                    o_valid,
    output logic [N_CHANNELS*SAMPLER_DATA_SIZE-1:0] o_data
);

    localparam int c_Z  = ZMOD_DATA_SIZE;
    localparam int c_S  = SAMPLER_DATA_SIZE;
    localparam int c_A  = SAMPLER_DATA_SIZE + MAX_AVG_LOG2;
    localparam int c_CW = MAX_AVG_LOG2 + 1;

    localparam logic [2:0]      c_MAX_K = 3'(MAX_AVG_LOG2);
    localparam logic [c_S-1:0]  c_HALF  = c_S'(2 ** (c_Z - 1));

    logic           r_s1_valid;
    logic [c_CW-1:0] r_count;
    logic [1:0]     r_mode;
    logic [2:0]     r_k;
    logic           r_o_valid;

    logic [2:0]      w_k_clamped;
    logic [c_CW-1:0] w_last_cnt;
    logic            w_last;
    logic            w_take;
    logic            w_add;
    logic            w_done;
    logic            w_first;
    logic            w_latch;
    logic [1:0]      w_cv_mode;
    logic            w_signed;

    assign w_k_clamped = (i_avg_log2 > c_MAX_K) ? c_MAX_K : i_avg_log2;
    assign w_last_cnt  = (c_CW'(1) << r_k) - c_CW'(1);
    assign w_last      = (r_count == w_last_cnt);
    assign w_take      = i_valid & ~i_clear;
    assign w_add       = r_s1_valid & ~i_clear;
    assign w_done      = w_add & w_last;

    // A new block starts either after an idle gap with an empty pipeline, or
    // right behind the sample that completes the current block in stage 2.
    assign w_first   = r_s1_valid ? w_last : (r_count == '0);
    assign w_latch   = w_take & w_first;
    assign w_cv_mode = w_latch ? i_mode : r_mode;
    assign w_signed  = r_mode[0];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_count    <= '0;
            r_mode     <= 2'd0;
            r_k        <= 3'd0;
            r_o_valid  <= 1'b0;
        end else begin
            r_s1_valid <= w_take;
            r_o_valid  <= w_done;
            if (w_latch) begin
                r_mode <= i_mode;
                r_k    <= w_k_clamped;
            end
            if (i_clear) begin
                r_count <= '0;
            end else if (w_add) begin
                r_count <= w_last ? '0 : r_count + c_CW'(1);
            end
        end
    end

    assign o_valid = r_o_valid;

    generate
        for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
            logic [c_Z-1:0] w_raw;
            logic [c_Z-1:0] w_tc;
            logic [c_S-1:0] w_raw_s;
            logic [c_S-1:0] w_m1;
            logic [c_S-1:0] w_m2;
            logic [c_S-1:0] w_m3;
            logic [c_S-1:0] w_conv;
            logic [c_A-1:0] w_ext;
            logic [c_A-1:0] w_sum;
            logic [c_S-1:0] w_avg;
            logic [c_S-1:0] r_s1_data;
            logic [c_A-1:0] r_acc;
            logic [c_S-1:0] r_out;

            assign w_raw   = i_raw_data[c*c_Z +: c_Z];
            assign w_tc    = {~w_raw[c_Z-1], w_raw[c_Z-2:0]};
            assign w_raw_s = c_S'(w_raw);
            assign w_m1    = c_S'($signed(w_tc));
            assign w_m2    = (w_raw_s > c_HALF) ? (w_raw_s - c_HALF) : (w_raw_s + c_HALF);
            assign w_m3    = w_m1 << (c_S - c_Z);

            always_comb begin
                w_conv = w_raw_s;
                case (w_cv_mode)
                    2'd1:    w_conv = w_m1;
                    2'd2:    w_conv = w_m2;
                    2'd3:    w_conv = w_m3;
                    default: w_conv = w_raw_s;
                endcase
            end

            assign w_ext = {{MAX_AVG_LOG2{w_signed & r_s1_data[c_S-1]}}, r_s1_data};
            assign w_sum = r_acc + w_ext;
            // The sum of 2^k in-range samples divided by 2^k is back in range,
            // so truncating the shifted value to S bits loses nothing.
            assign w_avg = w_signed ? c_S'($signed(w_sum) >>> r_k) : c_S'(w_sum >> r_k);

            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    r_s1_data <= '0;
                    r_acc     <= '0;
                    r_out     <= '0;
                end else begin
                    if (w_take) begin
                        r_s1_data <= w_conv;
                    end
                    if (i_clear) begin
                        r_acc <= '0;
                    end else if (w_add) begin
                        r_acc <= w_last ? '0 : w_sum;
                    end
                    if (w_done) begin
                        r_out <= w_avg;
                    end
                end
            end

            assign o_data[c*c_S +: c_S] = r_out;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_zmod_sample_conditioner.sv
// ============================================================================
// Module   : tb_zmod_sample_conditioner
// Brief    : Scoreboard bench for zmod_sample_conditioner with an integer
//            reference model of conversion and floor block averaging.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_zmod_sample_conditioner;

    localparam int N    = 2;
    localparam int Z    = 14;
    localparam int S    = 16;
    localparam int MAXK = 4;

    logic             clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_valid = 1'b0;
    logic [N*Z-1:0]   i_raw_data = '0;
    logic [1:0]       i_mode = 2'd0;
    logic [2:0]       i_avg_log2 = 3'd0;
    logic             i_clear = 1'b0;
    logic             o_valid;
    logic [N*S-1:0]   o_data;

    always #5 clk = ~clk;

    zmod_sample_conditioner #(
        .N_CHANNELS       (N),
        .ZMOD_DATA_SIZE   (Z),
        .SAMPLER_DATA_SIZE(S),
        .MAX_AVG_LOG2     (MAXK)
    ) dut (
        .i_clock   (clk),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .i_raw_data(i_raw_data),
        .i_mode    (i_mode),
        .i_avg_log2(i_avg_log2),
        .i_clear   (i_clear),
        .o_valid   (o_valid),
        .o_data    (o_data)
    );

    typedef struct {
        logic [N*S-1:0] data;
        int             cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    bit   rst_q = 1'b0;
    bit   armed = 1'b0;
    logic [N*S-1:0] hold = '0;
    int   n_tests = 0;
    int   n_fail = 0;

    // Reference model state: samples accepted in the current block and sums.
    int m_n = 0;
    int m_mode = 0;
    int m_k = 0;
    int m_sum[N];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= i_reset;
    end

    function automatic int conv(int x, int mode);
        case (mode)
            0:       return x;
            1:       return x - 8192;
            2:       return (x > 8192) ? x - 8192 : x + 8192;
            default: return (x - 8192) * 4;
        endcase
    endfunction

    function automatic int floordiv(int a, int d);
        int r;
        r = a / d;
        if ((a % d) != 0 && a < 0) r = r - 1;
        return r;
    endfunction

    function automatic logic [Z-1:0] rnd14();
        logic [Z-1:0] edges [5];
        edges[0] = 14'h0000; edges[1] = 14'h1FFF; edges[2] = 14'h2000;
        edges[3] = 14'h2001; edges[4] = 14'h3FFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return Z'($urandom_range(0, 16383));
    endfunction

    function automatic logic [N*Z-1:0] raw2(logic [Z-1:0] a, logic [Z-1:0] b);
        return {b, a};
    endfunction

    task automatic step(bit v, bit clr, bit rs, logic [N*Z-1:0] raw, int mode, int avg);
        exp_t e;
        @(posedge clk);
        #1;
        i_valid    = v;
        i_clear    = clr;
        i_reset    = rs;
        i_raw_data = raw;
        i_mode     = 2'(mode);
        i_avg_log2 = 3'(avg);
        if (rs || clr) begin
            while (q.size() > 0 && q[$].cyc == cyc + 1) void'(q.pop_back());
            m_n = 0;
            for (int c = 0; c < N; c++) m_sum[c] = 0;
        end else if (v) begin
            if (m_n == 0) begin
                m_mode = mode;
                m_k    = (avg > MAXK) ? MAXK : avg;
            end
            for (int c = 0; c < N; c++) m_sum[c] += conv(int'(raw[c*Z +: Z]), m_mode);
            m_n++;
            if (m_n == (1 << m_k)) begin
                for (int c = 0; c < N; c++)
                    e.data[c*S +: S] = S'(floordiv(m_sum[c], 1 << m_k));
                e.cyc = cyc + 2;
                q.push_back(e);
                m_n = 0;
                for (int c = 0; c < N; c++) m_sum[c] = 0;
            end
        end
    endtask

    task automatic idle(int n, int mode, int avg);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, mode, avg);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_q) armed = 1'b1;
        if (armed) begin
            if (rst_q) hold = '0;
            if (o_valid) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output cyc=%0d got=%h required=no output", cyc, o_data);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || o_data !== e.data) begin
                        n_fail++;
                        $display("FAIL output cyc=%0d got=%h required=%h at cyc %0d",
                                 cyc, o_data, e.data, e.cyc);
                    end
                    hold = e.data;
                end
            end else begin
                n_tests++;
                if (o_data !== hold) begin
                    n_fail++;
                    $display("FAIL hold cyc=%0d got=%h required=%h", cyc, o_data, hold);
                end
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_output cyc=%0d got=none required=%h", cyc, e.data);
                end
            end
        end
    end

    initial begin
        logic [Z-1:0] vals[4];
        int mode;
        int avg;
        int len;

        for (int c = 0; c < N; c++) m_sum[c] = 0;

        // Reset held with valid asserted
        repeat (3) step(1'b1, 1'b0, 1'b1, raw2(rnd14(), rnd14()), 1, 0);
        idle(2, 1, 0);

        // Mode 1, k=0
        step(1'b1, 1'b0, 1'b0, raw2(14'h0000, 14'h3FFF), 1, 0);
        step(1'b1, 1'b0, 1'b0, raw2(14'h2000, 14'h1FFF), 1, 0);
        idle(2, 1, 0);

        // Mode 2 boundaries
        vals[0] = 14'h2000; vals[1] = 14'h2001; vals[2] = 14'h1FFF; vals[3] = 14'h0000;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, raw2(vals[i], vals[3-i]), 2, 0);
        idle(2, 2, 0);

        // Mode 3 full scale
        step(1'b1, 1'b0, 1'b0, raw2(14'h3FFF, 14'h0000), 3, 0);
        step(1'b1, 1'b0, 1'b0, raw2(14'h0000, 14'h3FFF), 3, 0);
        idle(2, 3, 0);

        // Mode 1, k=2 floor averaging with idle gaps
        vals[0] = 14'h1FFC; vals[1] = 14'h1FFC; vals[2] = 14'h1FFD; vals[3] = 14'h1FFD;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, raw2(vals[i], rnd14()), 1, 2);
            idle($urandom_range(0, 3), 1, 2);
        end
        idle(3, 1, 2);

        // Clear mid-block (with a sample offered in the clear cycle)
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, raw2(rnd14(), rnd14()), 1, 2);
        step(1'b1, 1'b1, 1'b0, raw2(rnd14(), rnd14()), 1, 2);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, raw2(14'h2004, 14'h2004), 1, 2);
        idle(3, 1, 2);

        // Reset mid-block
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, raw2(rnd14(), rnd14()), 1, 2);
        step(1'b1, 1'b0, 1'b1, raw2(rnd14(), rnd14()), 1, 2);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, raw2(14'h2004, 14'h2004), 1, 2);
        idle(3, 1, 2);

        // Clamp of the averaging exponent
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b0, raw2(rnd14(), rnd14()), 0, 7);
        idle(3, 0, 7);

        // Random bursts; configuration changes may land mid-block
        for (int b = 0; b < 40; b++) begin
            mode = $urandom_range(0, 3);
            avg  = $urandom_range(0, 7);
            len  = $urandom_range(1, 40);
            for (int i = 0; i < len; i++)
                step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                     $urandom_range(0, 99) == 0, raw2(rnd14(), rnd14()), mode, avg);
        end
        idle(6, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
